// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with configurable frame format, internal baud counter
// and a TX FIFO behind a valid/ready handshake; frames are sent back-to-back.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16,
  localparam int LW          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_vld,
  output logic                 tx_rdy,
  output logic                 uart_tx,
  output logic                 busy,
  output logic                 tx_done,
  output logic [LW-1:0]        fifo_level
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_BITS);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad
    $error("uart_tx_fifo: illegal DATA_BITS/PARITY/STOP_BITS");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

  state_e               state_q;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [LW-1:0]        level_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] sh_q;
  logic                 par_q, tx_q;
  logic                 full, empty, push, pop, bit_end, stop_end;

  assign full     = level_q == LW'(FIFO_DEPTH);
  assign empty    = level_q == '0;
  assign push     = tx_vld && !full;
  assign bit_end  = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign stop_end = state_q == STOP && bit_end && bit_q == BW'(STOP_BITS - 1);
  // The next frame is fetched either from idle or on the very edge that ends the last stop bit.
  assign pop      = !empty && (state_q == IDLE || stop_end);

  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= tx_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop) rd_q <= rd_q + AW'(1);
      level_q <= level_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
    end else begin
      cnt_q <= bit_end ? '0 : cnt_q + CW'(1);
      if (pop) begin
        state_q <= START;
        tx_q    <= 1'b0;
        cnt_q   <= '0;
        sh_q    <= mem_q[rd_q];
        par_q   <= (PARITY == 2) ? ^mem_q[rd_q] : ~^mem_q[rd_q];
      end else begin
        case (state_q)
          IDLE: begin
            tx_q  <= 1'b1;
            cnt_q <= '0;
          end
          START: if (bit_end) begin
            state_q <= DATA;
            tx_q    <= sh_q[0];
            bit_q   <= '0;
          end
          DATA: if (bit_end) begin
            if (bit_q == BW'(DATA_BITS - 1)) begin
              state_q <= (PARITY != 0) ? PAR : STOP;
              tx_q    <= (PARITY != 0) ? par_q : 1'b1;
              bit_q   <= '0;
            end else begin
              bit_q <= bit_q + BW'(1);
              sh_q  <= sh_q >> 1;
              tx_q  <= sh_q[1];
            end
          end
          PAR: if (bit_end) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
            bit_q   <= '0;
          end
          STOP: if (bit_end) begin
            if (bit_q == BW'(STOP_BITS - 1)) begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_q + BW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign tx_rdy     = !full;
  assign uart_tx    = tx_q;
  assign busy       = state_q != IDLE || !empty;
  assign tx_done    = stop_end;
  assign fifo_level = level_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: four uart_tx_fifo formats (8N1, 8E1, 8O2, 7N1) run in lockstep and
// compared cycle by cycle against a frame-level line model.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DB[4] = '{8, 8, 8, 7};
  localparam int PR[4] = '{0, 2, 1, 0};
  localparam int SB[4] = '{1, 1, 2, 1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] data [4];
  logic       vld [4];
  logic       rdy [4];
  logic       tx [4];
  logic       bsy [4];
  logic       done [4];
  logic [2:0] lvl [4];

  int nv = 0;
  int nf = 0;

  // Model: fr holds the per-cycle line levels of the frame on the wire, rem its remaining
  // cycles; wq/wn are the words accepted but not yet started.
  logic [63:0] fr [4];
  int          rem [4];
  logic [8:0]  wq [4][8];
  int          wn [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_fifo #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(DB[g]), .PARITY(PR[g]), .STOP_BITS(SB[g]), .FIFO_DEPTH(4)
    ) dut (
      .clk(clk), .rst_n(rst_n), .tx_data(data[g][DB[g]-1:0]), .tx_vld(vld[g]), .tx_rdy(rdy[g]),
      .uart_tx(tx[g]), .busy(bsy[g]), .tx_done(done[g]), .fifo_level(lvl[g])
    );
  end

  function automatic logic [63:0] frame(input int k, input logic [8:0] w);
    logic [15:0] b;
    int ones;
    b = '1;
    b[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < DB[k]; i++) begin
      b[1+i] = w[i];
      ones += int'(w[i]);
    end
    if (PR[k] != 0) b[1+DB[k]] = (PR[k] == 2) ? ones[0] : !ones[0];
    for (int c = 0; c < 64; c++) frame[c] = b[c/CPB];
  endfunction

  function automatic int flen(input int k);
    return (1 + DB[k] + ((PR[k] != 0) ? 1 : 0) + SB[k]) * CPB;
  endfunction

  function automatic logic [6:0] exp_out(input int k);
    return {rem[k] > 0 ? fr[k][0] : 1'b1, rem[k] == 1, rem[k] > 0 || wn[k] > 0, wn[k] < 4, 3'(wn[k])};
  endfunction

  function automatic logic [6:0] got_out(input int k);
    return {tx[k], done[k], bsy[k], rdy[k], lvl[k]};
  endfunction

  function automatic bit idle();
    idle = 1'b1;
    for (int k = 0; k < 4; k++) if (rem[k] != 0 || wn[k] != 0) idle = 1'b0;
  endfunction

  task automatic set_vld(input logic v);
    for (int k = 0; k < 4; k++) vld[k] = v;
  endtask

  task automatic rand_data();
    for (int k = 0; k < 4; k++) data[k] = 9'($urandom);
  endtask

  task automatic tick();
    logic       v [4];
    logic [8:0] d [4];
    logic       r, acc;
    r = rst_n;
    for (int k = 0; k < 4; k++) begin
      v[k] = vld[k];
      d[k] = data[k];
    end
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (!r) begin
        rem[k] = 0;
        wn[k]  = 0;
      end else begin
        acc = v[k] && wn[k] < 4;
        if (rem[k] > 0) begin
          fr[k] = fr[k] >> 1;
          rem[k]--;
        end
        if (rem[k] == 0 && wn[k] > 0) begin
          fr[k]  = frame(k, wq[k][0]);
          rem[k] = flen(k);
          for (int i = 0; i < 7; i++) wq[k][i] = wq[k][i+1];
          wn[k]--;
        end
        if (acc) begin
          wq[k][wn[k]] = d[k];
          wn[k]++;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_vld(1'b1);
    rand_data();
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      nv++;
      if (got_out(k) !== 7'b1001000) begin
        nf++;
        $display("FAIL reset inst%0d {tx,done,busy,rdy,lvl} got %b exp 1001000", k, got_out(k));
      end
    end
    rst_n = 1'b1;
    set_vld(1'b0);
    tick();
  endtask

  task automatic test_frames();
    int pulses [4];
    for (int n = 0; n < 4; n++) begin
      rand_data();
      if (n == 0) begin
        data[0] = 9'h055;
        data[1] = 9'h007;
        data[2] = 9'h007;
        data[3] = 9'h07f;
      end
      for (int k = 0; k < 4; k++) pulses[k] = 0;
      set_vld(1'b1);
      for (int c = 0; c < 400; c++) begin
        tick();
        set_vld(1'b0);
        for (int k = 0; k < 4; k++) begin
          pulses[k] += int'(done[k]);
          nv++;
          if (got_out(k) !== exp_out(k)) begin
            nf++;
            $display("FAIL frame inst%0d word%0d cyc%0d got %b exp %b", k, n, c, got_out(k), exp_out(k));
          end
        end
        if (idle()) break;
      end
      for (int k = 0; k < 4; k++) begin
        nv++;
        if (pulses[k] !== 1 || !idle()) begin
          nf++;
          $display("FAIL frame_done inst%0d pulses got %0d exp 1 (idle=%0d)", k, pulses[k], idle());
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses [4];
    for (int k = 0; k < 4; k++) pulses[k] = 0;
    set_vld(1'b1);
    for (int c = 0; c < 400; c++) begin
      if (c < 3) rand_data();
      tick();
      if (c >= 2) set_vld(1'b0);
      for (int k = 0; k < 4; k++) begin
        pulses[k] += int'(done[k]);
        nv++;
        if (got_out(k) !== exp_out(k)) begin
          nf++;
          $display("FAIL b2b inst%0d cyc%0d got %b exp %b", k, c, got_out(k), exp_out(k));
        end
      end
      if (c >= 2 && idle()) break;
    end
    for (int k = 0; k < 4; k++) begin
      nv++;
      if (pulses[k] !== 3 || bsy[k] !== 1'b0) begin
        nf++;
        $display("FAIL b2b_done inst%0d pulses got %0d exp 3, busy got %b exp 0", k, pulses[k], bsy[k]);
      end
    end
  endtask

  task automatic test_full();
    set_vld(1'b1);
    for (int c = 0; c < 30; c++) begin
      rand_data();
      tick();
      for (int k = 0; k < 4; k++) begin
        nv++;
        if (got_out(k) !== exp_out(k)) begin
          nf++;
          $display("FAIL full inst%0d cyc%0d got %b exp %b", k, c, got_out(k), exp_out(k));
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      nv++;
      if (lvl[k] !== 3'd4 || rdy[k] !== 1'b0) begin
        nf++;
        $display("FAIL full_flag inst%0d lvl got %0d exp 4, rdy got %b exp 0", k, lvl[k], rdy[k]);
      end
    end
    set_vld(1'b0);
    for (int c = 0; c < 400 && !idle(); c++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        nv++;
        if (got_out(k) !== exp_out(k)) begin
          nf++;
          $display("FAIL full_drain inst%0d cyc%0d got %b exp %b", k, c, got_out(k), exp_out(k));
        end
      end
    end
    nv++;
    if (!idle()) begin
      nf++;
      $display("FAIL full_drain timeout got busy exp idle");
    end
  endtask

  task automatic test_push_pop();
    set_vld(1'b1);
    rand_data();
    tick();
    rand_data();
    tick();
    set_vld(1'b0);
    for (int c = 0; c < 100 && rem[0] != 1; c++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        nv++;
        if (got_out(k) !== exp_out(k)) begin
          nf++;
          $display("FAIL pushpop inst%0d cyc%0d got %b exp %b", k, c, got_out(k), exp_out(k));
        end
      end
    end
    nv++;
    if (rem[0] != 1 || lvl[0] !== 3'd1) begin
      nf++;
      $display("FAIL pushpop_setup lvl got %0d exp 1 at last stop cycle", lvl[0]);
    end
    set_vld(1'b1);
    rand_data();
    tick();
    set_vld(1'b0);
    nv++;
    if (lvl[0] !== 3'd1 || tx[0] !== 1'b0) begin
      nf++;
      $display("FAIL pushpop_level lvl got %0d exp 1, tx got %b exp 0", lvl[0], tx[0]);
    end
    for (int c = 0; c < 400 && !idle(); c++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        nv++;
        if (got_out(k) !== exp_out(k)) begin
          nf++;
          $display("FAIL pushpop_drain inst%0d cyc%0d got %b exp %b", k, c, got_out(k), exp_out(k));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    set_vld(1'b1);
    rand_data();
    tick();
    rand_data();
    tick();
    set_vld(1'b0);
    repeat (14) tick();
    rst_n = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      nv++;
      if (tx[k] !== 1'b1 || lvl[k] !== 3'd0 || bsy[k] !== 1'b0) begin
        nf++;
        $display("FAIL reset_mid inst%0d tx got %b exp 1, lvl got %0d exp 0, busy got %b exp 0", k, tx[k], lvl[k], bsy[k]);
      end
    end
    rst_n = 1'b1;
    tick();
    rand_data();
    set_vld(1'b1);
    for (int c = 0; c < 400; c++) begin
      tick();
      set_vld(1'b0);
      for (int k = 0; k < 4; k++) begin
        nv++;
        if (got_out(k) !== exp_out(k)) begin
          nf++;
          $display("FAIL reset_mid_frame inst%0d cyc%0d got %b exp %b", k, c, got_out(k), exp_out(k));
        end
      end
      if (idle()) break;
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      vld[k]  = 1'b0;
      data[k] = '0;
      rem[k]  = 0;
      wn[k]   = 0;
      fr[k]   = '1;
    end
    test_reset();
    test_frames();
    test_back_to_back();
    test_full();
    test_push_pop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  end
endmodule
